// File: rtl/alu_pkg.sv
// Shared definitions for the 6-bit ALU and its stimulus sequencer:
// datapath width, opcode numbering and the sequencer state encoding.
package alu_pkg;

    // ALU datapath width
    localparam int unsigned ALU_W = 6;

    // Opcode numbering as seen on the ALU sel input (13 and 14 are unused)
    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_A    = 4'd1;
    localparam logic [3:0] OP_B    = 4'd2;
    localparam logic [3:0] OP_GE   = 4'd3;
    localparam logic [3:0] OP_NEGA = 4'd4;
    localparam logic [3:0] OP_NEGB = 4'd5;
    localparam logic [3:0] OP_SHRA = 4'd6;
    localparam logic [3:0] OP_SHRB = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOTA = 4'd9;
    localparam logic [3:0] OP_NOTB = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_ADD  = 4'd12;
    localparam logic [3:0] OP_ONES = 4'd15;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

    // Counter reload value: the counter counts SETTLE-1 down to 0, so the
    // ALU inputs are held for SETTLE cycles before alu_x is sampled.
    function automatic logic [3:0] settle_load(input int unsigned settle);
        return 4'(settle - 1);
    endfunction

endpackage

// File: rtl/alu_next_op.sv
// Priority finder: lowest opcode enabled in MASK that lies strictly above
// cur. With from_start set, cur is ignored and the search begins below
// opcode 0, which gives the first enabled opcode of a batch.
module alu_next_op #(
    parameter logic [15:0] MASK = 16'h9FFF
) (
    input  logic [3:0] cur,
    input  logic       from_start,
    output logic [3:0] next_op,
    output logic       no_next
);

    // Scan from the top down so the last hit is the lowest qualifying opcode
    always_comb begin
        next_op = 4'd0;
        no_next = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (MASK[i] && (from_start || (i > int'(cur)))) begin
                next_op = 4'(i);
                no_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardware stimulus driver for the 6-bit ALU. A start pulse latches one
// operand pair; every opcode enabled in OP_MASK is then driven in ascending
// order, alu_x is sampled after SETTLE cycles and offered downstream over
// valid/ready tagged with its opcode. All outputs are registered.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W       = ALU_W,
    parameter int unsigned SETTLE  = 2,
    parameter logic [15:0] OP_MASK = 16'h9FFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [3:0]   alu_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_x,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [3:0]   res_sel,
    output logic [W-1:0] res_data,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] CNT_LOAD = settle_load(SETTLE);

    seq_state_t state;
    logic [3:0] cnt;
    logic [3:0] next_sel;
    logic       no_next;
    logic       from_start;

    // In IDLE the finder looks for the first enabled opcode; otherwise it
    // looks for the one after the opcode currently on alu_sel.
    assign from_start = (state == ST_IDLE);

    alu_next_op #(
        .MASK(OP_MASK)
    ) u_next_op (
        .cur       (alu_sel),
        .from_start(from_start),
        .next_op   (next_sel),
        .no_next   (no_next)
    );

    // Batch control FSM; every output is a register written here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            alu_sel   <= OP_ZERO;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_sel   <= 4'd0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // done is still high in the cycle right after FIN; a start
                    // seen then belongs to the batch that just ended.
                    if (start && !done) begin
                        alu_a <= a_in;
                        alu_b <= b_in;
                        busy  <= 1'b1;
                        if (!no_next) begin
                            alu_sel <= next_sel;
                            cnt     <= CNT_LOAD;
                            state   <= ST_DRIVE;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt == 4'd0) begin
                        res_data  <= alu_x;
                        res_sel   <= alu_sel;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        if (!no_next) begin
                            alu_sel <= next_sel;
                            cnt     <= CNT_LOAD;
                            state   <= ST_DRIVE;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances (default mask, two-opcode
// mask, empty mask) driven against a behavioural ALU, with a table of
// hand-computed results, scripted corner sequences and random batches.
`define CHK(n, g, e) check(n, 32'(g), 32'(e))

module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int          W        = ALU_W;
    localparam int          SETTLE_M = 2;
    localparam int          SETTLE_T = 3;
    localparam logic [15:0] MASK_M   = 16'h9FFF;
    localparam logic [15:0] MASK_T   = 16'h8001;
    localparam logic [15:0] MASK_Z   = 16'h0000;

    typedef struct {
        logic [3:0]   sel;
        logic [W-1:0] data;
        int           cyc;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        logic [W-1:0] want;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [W-1:0] a_drv, b_drv;

    logic         start_m, res_ready_m, res_valid_m, busy_m, done_m;
    logic [3:0]   alu_sel_m, res_sel_m;
    logic [W-1:0] alu_a_m, alu_b_m, alu_x_m, res_data_m;

    logic         start_t, res_ready_t, res_valid_t, busy_t, done_t;
    logic [3:0]   alu_sel_t, res_sel_t;
    logic [W-1:0] alu_a_t, alu_b_t, alu_x_t, res_data_t;

    logic         start_z, res_ready_z, res_valid_z, busy_z, done_z;
    logic [3:0]   alu_sel_z, res_sel_z;
    logic [W-1:0] alu_a_z, alu_b_z, alu_x_z, res_data_z;

    logic [15:0]  mask_m_v = MASK_M;
    logic [15:0]  mask_t_v = MASK_T;
    logic [W-1:0] exp_a, exp_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    res_t res_q_m[$];
    res_t res_q_t[$];
    int   done_q_m[$];
    int   done_cnt_t = 0;

    logic         prev_valid, prev_ready;
    logic [3:0]   prev_sel;
    logic [W-1:0] prev_data;

    // Behavioural 6-bit ALU, also the source of expected results
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            OP_ZERO: return '0;
            OP_A:    return a;
            OP_B:    return b;
            OP_GE:   return ($signed(a) >= $signed(b)) ? W'(1) : W'(0);
            OP_NEGA: return -a;
            OP_NEGB: return -b;
            OP_SHRA: return W'($signed(a) >>> 1);
            OP_SHRB: return W'($signed(b) >>> 1);
            OP_XOR:  return a ^ b;
            OP_NOTA: return ~a;
            OP_NOTB: return ~b;
            OP_SUB:  return a - b;
            OP_ADD:  return a + b;
            OP_ONES: return '1;
            default: return '0;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endfunction

    assign alu_x_m = alu_f(alu_sel_m, alu_a_m, alu_b_m);
    assign alu_x_t = alu_f(alu_sel_t, alu_a_t, alu_b_t);
    assign alu_x_z = alu_f(alu_sel_z, alu_a_z, alu_b_z);

    alu_op_sequencer #(.W(W), .SETTLE(SETTLE_M), .OP_MASK(MASK_M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .a_in(a_drv), .b_in(b_drv),
        .alu_sel(alu_sel_m), .alu_a(alu_a_m), .alu_b(alu_b_m), .alu_x(alu_x_m),
        .res_valid(res_valid_m), .res_ready(res_ready_m), .res_sel(res_sel_m),
        .res_data(res_data_m), .busy(busy_m), .done(done_m)
    );

    alu_op_sequencer #(.W(W), .SETTLE(SETTLE_T), .OP_MASK(MASK_T)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .a_in(a_drv), .b_in(b_drv),
        .alu_sel(alu_sel_t), .alu_a(alu_a_t), .alu_b(alu_b_t), .alu_x(alu_x_t),
        .res_valid(res_valid_t), .res_ready(res_ready_t), .res_sel(res_sel_t),
        .res_data(res_data_t), .busy(busy_t), .done(done_t)
    );

    alu_op_sequencer #(.W(W), .SETTLE(SETTLE_M), .OP_MASK(MASK_Z)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .a_in(a_drv), .b_in(b_drv),
        .alu_sel(alu_sel_z), .alu_a(alu_a_z), .alu_b(alu_b_z), .alu_x(alu_x_z),
        .res_valid(res_valid_z), .res_ready(res_ready_z), .res_sel(res_sel_z),
        .res_data(res_data_z), .busy(busy_z), .done(done_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main-instance monitor: collects accepted results and done pulses,
    // checks that a stalled result holds and operands stay latched.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                n_checks = n_checks + 3;
                if (res_valid_m !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_stall_valid: got %0b", res_valid_m);
                end
                if (res_sel_m !== prev_sel) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_stall_sel: got %0d, expected %0d", res_sel_m, prev_sel);
                end
                if (res_data_m !== prev_data) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_stall_data: got %0d, expected %0d", res_data_m, prev_data);
                end
            end
            if (res_valid_m && res_ready_m)
                res_q_m.push_back('{sel: res_sel_m, data: res_data_m, cyc: cyc});
            if (done_m) begin
                done_q_m.push_back(cyc);
                n_checks = n_checks + 1;
                if (busy_m !== 1'b0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_busy_low_at_done: got %0b", busy_m);
                end
            end
            if (busy_m) begin
                n_checks = n_checks + 3;
                if (alu_a_m !== exp_a) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_alu_a_latched: got %0d, expected %0d", alu_a_m, exp_a);
                end
                if (alu_b_m !== exp_b) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_alu_b_latched: got %0d, expected %0d", alu_b_m, exp_b);
                end
                if (mask_m_v[alu_sel_m] !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL m_sel_enabled: alu_sel %0d", alu_sel_m);
                end
            end
            prev_valid <= res_valid_m;
            prev_ready <= res_ready_m;
            prev_sel   <= res_sel_m;
            prev_data  <= res_data_m;
        end
    end

    // Two-opcode instance monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid_t && res_ready_t)
                res_q_t.push_back('{sel: res_sel_t, data: res_data_t, cyc: cyc});
            if (done_t) done_cnt_t <= done_cnt_t + 1;
            if (busy_t) begin
                n_checks = n_checks + 1;
                if (mask_t_v[alu_sel_t] !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL t_sel_enabled: alu_sel %0d", alu_sel_t);
                end
            end
        end
    end

    task automatic start_main(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        @(posedge clk); #1;
        a_drv = a; b_drv = b; exp_a = a; exp_b = b;
        start_m = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start_m = 1'b0;
    endtask

    task automatic wait_done_m(input int budget, input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (rand_ready) res_ready_m = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_m) seen = 1'b1;
        end
        res_ready_m = 1'b1;
        `CHK("m_done_within_budget", seen, 1);
        @(negedge clk);
    endtask

    // Reference: one result per enabled opcode, ascending, value from the ALU
    task automatic check_batch_m(input logic [W-1:0] a, input logic [W-1:0] b, input int s,
                                 input bit timing);
        res_t exp_q[$];
        for (int op = 0; op < 16; op++)
            if (mask_m_v[op]) exp_q.push_back('{sel: 4'(op), data: alu_f(4'(op), a, b), cyc: 0});
        `CHK("m_result_count", res_q_m.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < res_q_m.size(); i++) begin
            `CHK($sformatf("m_res_sel[%0d]", i), res_q_m[i].sel, exp_q[i].sel);
            `CHK($sformatf("m_res_data[%0d]", i), res_q_m[i].data, exp_q[i].data);
            if (timing) begin
                if (i == 0) `CHK("m_first_latency", res_q_m[0].cyc - s, SETTLE_M + 1);
                else `CHK("m_result_spacing", res_q_m[i].cyc - res_q_m[i-1].cyc, SETTLE_M + 1);
            end
        end
        `CHK("m_done_count", done_q_m.size(), 1);
        if (done_q_m.size() > 0 && res_q_m.size() > 0)
            `CHK("m_done_after_last", done_q_m[0] - res_q_m[$].cyc, 2);
        res_q_m.delete();
        done_q_m.delete();
    endtask

    initial begin
        vec_t vecs[11];
        int   s;
        bit   seen;
        bit   found;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd8,  want: 6'b000110};
        vecs[1]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd12, want: 6'b110110};
        vecs[2]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd11, want: 6'b111110};
        vecs[3]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd9,  want: 6'b100101};
        vecs[4]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd1,  want: 6'b011010};
        vecs[5]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd15, want: 6'b111111};
        vecs[6]  = '{a: 6'b011010, b: 6'b011100, sel: 4'd0,  want: 6'b000000};
        vecs[7]  = '{a: 6'b000101, b: 6'b000011, sel: 4'd12, want: 6'b001000};
        vecs[8]  = '{a: 6'b000101, b: 6'b000011, sel: 4'd11, want: 6'b000010};
        vecs[9]  = '{a: 6'b000101, b: 6'b000011, sel: 4'd4,  want: 6'b111011};
        vecs[10] = '{a: 6'b000101, b: 6'b000011, sel: 4'd10, want: 6'b111100};

        rst_n = 1'b0;
        start_m = 1'b0; start_t = 1'b0; start_z = 1'b0;
        res_ready_m = 1'b1; res_ready_t = 1'b1; res_ready_z = 1'b1;
        a_drv = '0; b_drv = '0; exp_a = '0; exp_b = '0;

        // Reset values
        repeat (2) @(negedge clk);
        `CHK("rst_alu_sel", alu_sel_m, 0);
        `CHK("rst_alu_a", alu_a_m, 0);
        `CHK("rst_alu_b", alu_b_m, 0);
        `CHK("rst_res_valid", res_valid_m, 0);
        `CHK("rst_res_sel", res_sel_m, 0);
        `CHK("rst_res_data", res_data_m, 0);
        `CHK("rst_busy", busy_m, 0);
        `CHK("rst_done", done_m, 0);
        rst_n = 1'b1;

        // Table of hand-computed results, each from a full batch
        for (int v = 0; v < 11; v++) begin
            res_q_m.delete();
            done_q_m.delete();
            start_main(vecs[v].a, vecs[v].b, s);
            wait_done_m(200, 1'b0);
            found = 1'b0;
            foreach (res_q_m[i]) begin
                if (res_q_m[i].sel == vecs[v].sel) begin
                    found = 1'b1;
                    `CHK($sformatf("vec%0d_data_op%0d", v, vecs[v].sel), res_q_m[i].data, vecs[v].want);
                end
            end
            `CHK($sformatf("vec%0d_op_present", v), found, 1);
            check_batch_m(vecs[v].a, vecs[v].b, s, 1'b1);
        end

        // Backpressure on the opcode-1 result
        start_main(6'b011010, 6'b011100, s);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid_m && res_sel_m == 4'd0) seen = 1'b1;
        end
        `CHK("bp_op0_offered", seen, 1);
        @(posedge clk); #1;
        res_ready_m = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid_m) seen = 1'b1;
        end
        `CHK("bp_op1_offered", seen, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            `CHK("bp_valid", res_valid_m, 1);
            `CHK("bp_res_sel", res_sel_m, 1);
            `CHK("bp_res_data", res_data_m, 6'b011010);
            `CHK("bp_alu_sel", alu_sel_m, 1);
        end
        @(posedge clk); #1;
        res_ready_m = 1'b1;
        wait_done_m(200, 1'b0);
        check_batch_m(6'b011010, 6'b011100, s, 1'b0);

        // Start re-pulsed mid-batch with different operands
        start_main(6'b011010, 6'b011100, s);
        repeat (10) @(posedge clk);
        #1;
        a_drv = 6'b000001; b_drv = 6'b111111; start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        wait_done_m(200, 1'b0);
        check_batch_m(6'b011010, 6'b011100, s, 1'b1);

        // Mask with only opcodes 0 and 15, SETTLE=3
        @(posedge clk); #1;
        a_drv = 6'b101100; b_drv = 6'b010011; start_t = 1'b1; s = cyc;
        @(posedge clk); #1;
        start_t = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_t) seen = 1'b1;
        end
        `CHK("t_done_seen", seen, 1);
        @(negedge clk);
        `CHK("t_result_count", res_q_t.size(), 2);
        if (res_q_t.size() == 2) begin
            `CHK("t_sel0", res_q_t[0].sel, 0);
            `CHK("t_sel1", res_q_t[1].sel, 15);
            `CHK("t_data0", res_q_t[0].data, 0);
            `CHK("t_data1", res_q_t[1].data, 6'b111111);
            `CHK("t_first_latency", res_q_t[0].cyc - s, SETTLE_T + 1);
            `CHK("t_spacing", res_q_t[1].cyc - res_q_t[0].cyc, SETTLE_T + 1);
        end
        `CHK("t_done_count", done_cnt_t, 1);

        // Empty mask: busy for one cycle, done two cycles after start
        @(posedge clk); #1;
        start_z = 1'b1; s = cyc;
        @(posedge clk); #1;
        start_z = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            `CHK("z_busy", busy_z, (cyc - s) == 1);
            `CHK("z_done", done_z, (cyc - s) == 2);
            `CHK("z_no_valid", res_valid_z, 0);
            `CHK("z_res_data", res_data_z, 0);
            `CHK("z_res_sel", res_sel_z, 0);
            `CHK("z_alu_sel", alu_sel_z, 0);
        end

        // Start during the done cycle is ignored, accepted one cycle later
        @(posedge clk); #1;
        start_z = 1'b1;
        @(posedge clk); #1;
        start_z = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done_z) seen = 1'b1;
        end
        `CHK("z_done_seen", seen, 1);
        start_z = 1'b1;
        @(negedge clk);
        `CHK("z_start_in_done_ignored", busy_z, 0);
        @(negedge clk);
        `CHK("z_start_after_done_taken", busy_z, 1);
        start_z = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done_z) seen = 1'b1;
        end
        `CHK("z_second_done", seen, 1);

        // Asynchronous reset during the opcode-5 DRIVE
        start_main(6'b011010, 6'b011100, s);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busy_m && alu_sel_m == 4'd5 && !res_valid_m) seen = 1'b1;
        end
        `CHK("rst_op5_reached", seen, 1);
        #1;
        rst_n = 1'b0;
        #1;
        `CHK("arst_alu_sel", alu_sel_m, 0);
        `CHK("arst_alu_a", alu_a_m, 0);
        `CHK("arst_alu_b", alu_b_m, 0);
        `CHK("arst_res_valid", res_valid_m, 0);
        `CHK("arst_res_sel", res_sel_m, 0);
        `CHK("arst_res_data", res_data_m, 0);
        `CHK("arst_busy", busy_m, 0);
        `CHK("arst_done", done_m, 0);
        res_q_m.delete();
        done_q_m.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        `CHK("arst_no_results_after", res_q_m.size(), 0);
        `CHK("arst_no_done_after", done_q_m.size(), 0);
        `CHK("arst_idle_after", busy_m, 0);
        start_main(6'b011010, 6'b011100, s);
        wait_done_m(200, 1'b0);
        check_batch_m(6'b011010, 6'b011100, s, 1'b1);

        // Random operands with random consumer backpressure
        for (int r = 0; r < 6; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            res_q_m.delete();
            done_q_m.delete();
            start_main(ra, rb, s);
            wait_done_m(400, 1'b1);
            check_batch_m(ra, rb, s, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
